// File: rtl/full_adder.sv
// Purpose: WIDTH-bit ripple-carry full adder with a registered copy of the result.
// Latency: sum/cout are combinational (0 cycles); sum_q/cout_q are 1 cycle.
// Backpressure: none. Optional self-check comparator built when FA_CHECK_EN is defined.
module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q
`ifdef FA_CHECK_EN
  ,
  output logic             err
`endif
);

  // carry[i] is the carry into bit i; carry[WIDTH] is the carry out of the MSB.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;

  // Ripple the carry through the majority function, one cell per bit.
  always_comb begin
    carry    = '0;
    carry[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      carry[i+1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
    end
  end

  // Sum bits and carry out follow directly from the carry chain.
  always_comb begin
    sum_d  = a ^ b ^ carry[WIDTH-1:0];
    cout_d = carry[WIDTH];
  end

  assign sum  = sum_d;
  assign cout = cout_d;

  // Registered copy; async reset clears it without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

`ifdef FA_CHECK_EN
  // Arithmetic reference, widened by one bit so the carry out is never lost.
  logic [WIDTH:0] ref_sum;
  logic           mismatch;

  // Compare the ripple result against a plain addition.
  always_comb begin
    ref_sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    mismatch = (ref_sum != {cout_d, sum_d});
  end

  logic err_q;

  // Sticky error flag: set on any sampled mismatch, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (mismatch) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_full_adder.sv
// Testbench for full_adder: WIDTH=1 and WIDTH=8 instances checked against a
// scoreboard of expected results queued when stimulus is applied.
// Build with FA_CHECK_EN defined to also exercise the sticky err flag.
module tb_full_adder;

  logic       clk;
  logic       rst_n;

  logic       a1, b1, cin1;
  logic       sum1, cout1, sumq1, coutq1;

  logic [7:0] a8, b8;
  logic       cin8;
  logic [7:0] sum8, sumq8;
  logic       cout8, coutq8;

`ifdef FA_CHECK_EN
  logic       err1, err8;
`endif

  int n_checks;
  int n_errors;

  // Scoreboard queues: combinational and registered expectations.
  logic [8:0] comb_sb[$];
  logic [8:0] reg_sb[$];

  full_adder #(.WIDTH(1)) dut1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a1),
    .b      (b1),
    .cin    (cin1),
    .sum    (sum1),
    .cout   (cout1),
    .sum_q  (sumq1),
    .cout_q (coutq1)
`ifdef FA_CHECK_EN
    ,
    .err    (err1)
`endif
  );

  full_adder #(.WIDTH(8)) dut8 (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a8),
    .b      (b8),
    .cin    (cin8),
    .sum    (sum8),
    .cout   (cout8),
    .sum_q  (sumq8),
    .cout_q (coutq8)
`ifdef FA_CHECK_EN
    ,
    .err    (err8)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_comb(input string tag, input logic [8:0] obs);
    if (comb_sb.size() == 0) check({tag, "_sb_empty"}, 32'd0, 32'd1);
    else check(tag, 32'(obs), 32'(comb_sb.pop_front()));
  endtask

  task automatic sb_reg(input string tag, input logic [8:0] obs);
    if (reg_sb.size() == 0) check({tag, "_sb_empty"}, 32'd0, 32'd1);
    else check(tag, 32'(obs), 32'(reg_sb.pop_front()));
  endtask

  // Drive the 1-bit DUT and queue its expected result from the truth tables.
  task automatic drive1(input logic [2:0] v);
    logic [7:0] sum_tbl;
    logic [7:0] cout_tbl;
    logic [8:0] e;
    sum_tbl  = 8'b1001_0110;
    cout_tbl = 8'b1110_1000;
    {a1, b1, cin1} = v;
    e = {7'd0, cout_tbl[v], sum_tbl[v]};
    comb_sb.push_back(e);
    reg_sb.push_back(e);
  endtask

  // Drive the 8-bit DUT and queue the arithmetic model result.
  task automatic drive8(input logic [7:0] va, input logic [7:0] vb, input logic vc);
    logic [8:0] e;
    a8 = va; b8 = vb; cin8 = vc;
    e = {1'b0, va} + {1'b0, vb} + {8'd0, vc};
    comb_sb.push_back(e);
    reg_sb.push_back(e);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    a8 = 8'd0; b8 = 8'd0; cin8 = 1'b0;

    // Reset state of the registered outputs.
    @(negedge clk); #1;
    check("rst_sum_q", 32'(sumq1), 32'd0);
    check("rst_cout_q", 32'(coutq1), 32'd0);
    check("rst_sum_q8", 32'(sumq8), 32'd0);

    // Combinational path is live during reset; registers stay cleared.
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b0; cin1 = 1'b1;
    #1;
    check("rst_comb_sum", 32'(sum1), 32'd0);
    check("rst_comb_cout", 32'(cout1), 32'd1);
    @(posedge clk); #1;
    check("rst_hold_sum_q", 32'(sumq1), 32'd0);
    check("rst_hold_cout_q", 32'(coutq1), 32'd0);

    // Release reset and show the one-cycle latency of the registers.
    @(negedge clk);
    rst_n = 1'b1;
    drive1(3'b110);
    #1;
    sb_comb("lat_comb", {7'd0, cout1, sum1});
    check("lat_before_cout_q", 32'(coutq1), 32'd0);
    @(posedge clk); #1;
    sb_reg("lat_reg", {7'd0, coutq1, sumq1});

    // Exhaustive 1-bit sweep, 10 ns per step.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive1(3'(i));
      #1;
      sb_comb($sformatf("exh_comb_%0d", i), {7'd0, cout1, sum1});
      @(posedge clk); #1;
      sb_reg($sformatf("exh_reg_%0d", i), {7'd0, coutq1, sumq1});
    end

`ifdef FA_CHECK_EN
    check("err1_clean", 32'(err1), 32'd0);
`endif

    // 8-bit directed boundaries followed by a few random operands.
    @(negedge clk);
    drive8(8'hFF, 8'h01, 1'b0);
    #1;
    sb_comb("w8_ff_01", {cout8, sum8});
    @(posedge clk); #1;
    sb_reg("w8_ff_01_reg", {coutq8, sumq8});
    @(negedge clk);
    drive8(8'hFF, 8'hFF, 1'b1);
    #1;
    sb_comb("w8_ff_ff_1", {cout8, sum8});
    @(posedge clk); #1;
    sb_reg("w8_ff_ff_1_reg", {coutq8, sumq8});
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      #1;
      sb_comb($sformatf("w8_rnd_%0d", i), {cout8, sum8});
      @(posedge clk); #1;
      sb_reg($sformatf("w8_rnd_reg_%0d", i), {coutq8, sumq8});
    end

`ifdef FA_CHECK_EN
    check("err8_clean", 32'(err8), 32'd0);
`endif

    // Async reset between edges: registers clear at once, comb keeps tracking.
    @(negedge clk);
    drive1(3'b100);
    #1;
    sb_comb("ar_comb", {7'd0, cout1, sum1});
    @(posedge clk); #1;
    sb_reg("ar_pre_sum_q", {7'd0, coutq1, sumq1});
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_sum_q", 32'(sumq1), 32'd0);
    check("ar_cout_q", 32'(coutq1), 32'd0);
    drive1(3'b111);
    reg_sb.delete();
    #1;
    sb_comb("ar_comb_track", {7'd0, cout1, sum1});
    check("ar_hold_sum_q", 32'(sumq1), 32'd0);

`ifdef FA_CHECK_EN
    // Corrupt the carry chain for one edge and expect a sticky err.
    @(negedge clk);
    rst_n = 1'b1;
    a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    @(negedge clk);
    force dut1.carry = 2'b11;
    @(posedge clk); #1;
    check("err_set", 32'(err1), 32'd1);
    @(negedge clk);
    release dut1.carry;
    @(posedge clk); #1;
    check("err_sticky", 32'(err1), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("err_cleared", 32'(err1), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
